// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive frame controller.
package uart_rx_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned PRESC_W = 6;

  localparam logic [3:0]         BIT_START  = 4'd0;
  localparam logic [3:0]         BIT_PAR    = 4'd9;
  localparam logic [PRESC_W-1:0] MIN_PRESC  = 6'd4;
  localparam logic [PRESC_W-1:0] DFLT_PRESC = 6'd8;
  localparam logic [PRESC_W-1:0] PRESC_ONE  = 6'd1;

  typedef enum logic [5:0] {
    IDLE   = 6'b000001,
    START  = 6'b000010,
    DATA   = 6'b000100,
    PARITY = 6'b001000,
    STOP   = 6'b010000,
    CHECK  = 6'b100000
  } rx_state_e;

  // Ratios too small to place a mid-bit sample fall back to the default.
  function automatic logic [PRESC_W-1:0] eff_presc(input logic [PRESC_W-1:0] p);
    return (p < MIN_PRESC) ? DFLT_PRESC : p;
  endfunction

  function automatic logic calc_parity(input logic [DATA_W-1:0] d, input logic typ);
    return (^d) ^ typ;
  endfunction

endpackage

// File: rtl/uart_rx_fsm_if.sv
// Signal bundle between the receive frame controller and its sampler, parity checker and sink.
interface uart_rx_fsm_if;
  import uart_rx_pkg::*;

  logic               rx_in;
  logic [PRESC_W-1:0] prescale;
  logic               par_en;
  logic               par_typ;
  logic               sampled_bit;
  logic               sample_vld;
  logic               par_error;
  logic               dat_samp_en;
  logic [PRESC_W-1:0] edge_cnt;
  logic [3:0]         bit_cnt;
  logic               done;
  logic               par_chk_en;
  logic               calculated_par;
  logic               strt_glitch;
  logic               stp_error;
  logic [DATA_W-1:0]  p_data;
  logic               data_valid;

  modport slave (
    input  rx_in, prescale, par_en, par_typ, sampled_bit, sample_vld, par_error,
    output dat_samp_en, edge_cnt, bit_cnt, done, par_chk_en, calculated_par,
           strt_glitch, stp_error, p_data, data_valid
  );

  modport master (
    output rx_in, prescale, par_en, par_typ, sampled_bit, sample_vld, par_error,
    input  dat_samp_en, edge_cnt, bit_cnt, done, par_chk_en, calculated_par,
           strt_glitch, stp_error, p_data, data_valid
  );

endinterface

// File: rtl/uart_rx_fsm_edge_bit_counter.sv
// Oversample edge counter and frame bit counter: clears while idle, counts while
// enabled and holds otherwise, so the final bit index survives through CHECK.
module edge_bit_counter
  import uart_rx_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr_i,
  input  logic               en_i,
  input  logic [PRESC_W-1:0] presc_i,
  output logic [PRESC_W-1:0] edge_cnt_o,
  output logic [3:0]         bit_cnt_o,
  output logic               bit_wrap_o
);

  logic [PRESC_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [3:0]         bit_cnt_q, bit_cnt_d;
  logic               last_edge;

  assign last_edge  = (edge_cnt_q == (presc_i - PRESC_ONE));
  assign edge_cnt_o = edge_cnt_q;
  assign bit_cnt_o  = bit_cnt_q;

  // Next-count logic and bit wrap strobe.
  always_comb begin
    edge_cnt_d = edge_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    bit_wrap_o = 1'b0;
    if (clr_i) begin
      edge_cnt_d = '0;
      bit_cnt_d  = BIT_START;
    end else if (en_i) begin
      if (last_edge) begin
        edge_cnt_d = '0;
        bit_cnt_d  = bit_cnt_q + 4'd1;
        bit_wrap_o = 1'b1;
      end else begin
        edge_cnt_d = edge_cnt_q + PRESC_ONE;
      end
    end else begin
      edge_cnt_d = edge_cnt_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      edge_cnt_q <= '0;
      bit_cnt_q  <= 4'd0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive frame controller: walks start/data/parity/stop bits, deserialises
// the byte and publishes it once the stop bit and parity checker agree.
module uart_rx_fsm
  import uart_rx_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  uart_rx_fsm_if.slave bus
);

  rx_state_e          state_q, state_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               par_en_q, par_en_d;
  logic               par_typ_q, par_typ_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic [DATA_W-1:0]  p_data_q, p_data_d;
  logic               stp_err_q, stp_err_d;
  logic               glitch_q, glitch_d;

  logic               cnt_en;
  logic               cnt_clr;
  logic               bit_wrap;
  logic               done;
  logic               frame_ok;
  logic [PRESC_W-1:0] edge_cnt;
  logic [3:0]         bit_cnt;

  assign cnt_clr  = (state_q == IDLE);
  assign cnt_en   = (state_q == START) || (state_q == DATA) ||
                    (state_q == PARITY) || (state_q == STOP);
  assign done     = bus.sample_vld && (state_q != IDLE);
  assign frame_ok = !stp_err_q && !(par_en_q && bus.par_error);

  edge_bit_counter u_cnt (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (cnt_clr),
    .en_i       (cnt_en),
    .presc_i    (presc_q),
    .edge_cnt_o (edge_cnt),
    .bit_cnt_o  (bit_cnt),
    .bit_wrap_o (bit_wrap)
  );

  assign bus.dat_samp_en    = cnt_en;
  assign bus.edge_cnt       = edge_cnt;
  assign bus.bit_cnt        = bit_cnt;
  assign bus.done           = done;
  assign bus.par_chk_en     = (state_q == PARITY);
  assign bus.calculated_par = calc_parity(shift_q, par_typ_q);
  assign bus.strt_glitch    = glitch_q;
  assign bus.stp_error      = stp_err_q;
  assign bus.p_data         = p_data_q;
  assign bus.data_valid     = (state_q == CHECK) && frame_ok;

  // Frame sequencing, deserialisation and result capture.
  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    shift_d   = shift_q;
    p_data_d  = p_data_q;
    stp_err_d = stp_err_q;
    glitch_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!bus.rx_in) begin
          // Frame configuration is frozen here for the whole frame.
          state_d   = START;
          presc_d   = eff_presc(bus.prescale);
          par_en_d  = bus.par_en;
          par_typ_d = bus.par_typ;
          stp_err_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (done && bus.sampled_bit) begin
          glitch_d = 1'b1;
          state_d  = IDLE;
        end else if (bit_wrap) begin
          state_d = DATA;
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (done) begin
          shift_d = {bus.sampled_bit, shift_q[DATA_W-1:1]};
        end else begin
          shift_d = shift_q;
        end
        if (bit_wrap && (bit_cnt == (BIT_PAR - 4'd1))) begin
          state_d = par_en_q ? PARITY : STOP;
        end else begin
          state_d = DATA;
        end
      end
      PARITY: begin
        if (bit_wrap) begin
          state_d = STOP;
        end else begin
          state_d = PARITY;
        end
      end
      STOP: begin
        // Leave at the stop sample so the next start edge is always caught.
        if (done) begin
          stp_err_d = ~bus.sampled_bit;
          state_d   = CHECK;
        end else begin
          state_d = STOP;
        end
      end
      CHECK: begin
        state_d = IDLE;
        if (frame_ok) begin
          p_data_d = shift_q;
        end else begin
          p_data_d = p_data_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      presc_q   <= DFLT_PRESC;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      shift_q   <= '0;
      p_data_q  <= '0;
      stp_err_q <= 1'b0;
      glitch_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      shift_q   <= shift_d;
      p_data_q  <= p_data_d;
      stp_err_q <= stp_err_d;
      glitch_q  <= glitch_d;
    end
  end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Self-checking bench for uart_rx_fsm: serial line, mid-bit sampler and parity
// checker are modelled here; frame outcomes are predicted from the frame contents.
module tb_uart_rx_fsm;
  import uart_rx_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_rx_fsm_if bus ();

  uart_rx_fsm dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  bit         line_q[$];
  logic [7:0] pd_q[$];
  int         cur_p    = 8;
  int         cur_stop = 9;
  logic       calc_exp = 1'b0;
  int         dv_cnt, gl_cnt, max_bit;
  logic       stp_seen, perr_seen;
  logic       rec_pd  = 1'b0;
  logic       rec_stp = 1'b0;
  logic [7:0] exp_pd  = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {7'd0, bus.dat_samp_en, bus.edge_cnt, bus.bit_cnt, bus.done, bus.par_chk_en,
            bus.calculated_par, bus.strt_glitch, bus.stp_error, bus.p_data, bus.data_valid};
  endfunction

  // One clock: par_chk register update, line/sampler drive, then observation.
  task automatic tick();
    logic nxt;
    #1;
    nxt = bus.par_error;
    if (bus.bit_cnt == 4'd0) nxt = 1'b0;
    else if (bus.par_chk_en && bus.done) nxt = bus.sampled_bit ^ bus.calculated_par;
    @(posedge clk);
    #1;
    bus.par_error = rst ? nxt : 1'b0;
    if (rec_pd) begin pd_q.push_back(bus.p_data); rec_pd = 1'b0; end
    if (rec_stp) begin stp_seen = bus.stp_error; rec_stp = 1'b0; end
    bus.rx_in       = (line_q.size() > 0) ? line_q.pop_front() : 1'b1;
    bus.sampled_bit = bus.rx_in;
    bus.sample_vld  = bus.dat_samp_en && (int'(bus.edge_cnt) == cur_p / 2);
    if (bus.sample_vld && int'(bus.bit_cnt) == cur_stop) rec_stp = 1'b1;
    #1;
    if (bus.data_valid) begin dv_cnt++; rec_pd = 1'b1; end
    if (bus.strt_glitch) gl_cnt++;
    if (int'(bus.bit_cnt) > max_bit) max_bit = int'(bus.bit_cnt);
    if (bus.dat_samp_en && bus.bit_cnt == 4'd10 && bus.par_error) perr_seen = 1'b1;
    if (bus.par_chk_en) chk("calc_par", {31'd0, bus.calculated_par}, {31'd0, calc_exp});
  endtask

  task automatic push_frame(input int p, input logic [5:0] presc_in, input logic [7:0] d,
                            input bit pe, input bit pt, input bit bad_par, input bit stop);
    logic pb;
    pb = (^d) ^ pt ^ bad_par;
    repeat (p) line_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) repeat (p) line_q.push_back(d[i]);
    if (pe) repeat (p) line_q.push_back(pb);
    repeat (p) line_q.push_back(stop);
    cur_p        = p;
    cur_stop     = pe ? 10 : 9;
    calc_exp     = (^d) ^ pt;
    bus.prescale = presc_in;
    bus.par_en   = pe;
    bus.par_typ  = pt;
  endtask

  task automatic clear_obs();
    dv_cnt = 0; gl_cnt = 0; max_bit = 0;
    perr_seen = 1'b0; stp_seen = 1'bx;
    pd_q.delete();
  endtask

  task automatic drain(input bit scramble);
    int k;
    k = 0;
    while (line_q.size() > 0 && k < 5000) begin
      tick();
      k++;
      if (scramble && k == 2 * cur_p) begin
        bus.prescale = 6'($urandom_range(0, 63));
        bus.par_en   = 1'($urandom_range(0, 1));
        bus.par_typ  = 1'($urandom_range(0, 1));
      end
    end
    repeat (3) tick();
  endtask

  // Single frame with outcome predicted from its contents.
  task automatic do_frame(input string tag, input int p, input logic [5:0] presc_in,
                          input logic [7:0] d, input bit pe, input bit pt,
                          input bit bad_par, input bit bad_stop, input bit scramble);
    bit ok;
    ok = !bad_stop && !(pe && bad_par);
    clear_obs();
    push_frame(p, presc_in, d, pe, pt, bad_par, !bad_stop);
    if (bad_stop) repeat (2 * p) line_q.push_back(1'b1);
    drain(scramble && !bad_stop);
    if (ok) exp_pd = d;
    chk({tag, "_dv"}, dv_cnt, {31'd0, ok});
    chk({tag, "_pdata"}, {24'd0, bus.p_data}, {24'd0, exp_pd});
    chk({tag, "_stp"}, {31'd0, stp_seen}, {31'd0, bad_stop});
    chk({tag, "_glitch"}, gl_cnt, {31'd0, bad_stop});
    if (pe) chk({tag, "_perr"}, {31'd0, perr_seen}, {31'd0, bad_par});
    if (ok) begin
      chk({tag, "_npd"}, pd_q.size(), 32'd1);
      chk({tag, "_pd0"}, {24'd0, pd_q[0]}, {24'd0, d});
    end
  endtask

  initial begin
    int k;
    bit pe, pt, bp, bs;
    int p;
    rst = 1'b0;
    bus.rx_in = 1'b1; bus.prescale = 6'd8; bus.par_en = 1'b0; bus.par_typ = 1'b0;
    bus.sampled_bit = 1'b1; bus.sample_vld = 1'b0; bus.par_error = 1'b0;
    clear_obs();
    repeat (3) tick();
    chk("reset_outs", all_outs(), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) tick();

    do_frame("a5_ok", 8, 6'd8, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    do_frame("a5_perr", 8, 6'd8, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    do_frame("3c_stp", 16, 6'd16, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    do_frame("81_ok", 16, 6'd16, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Short low pulse on the line: a false start.
    clear_obs();
    cur_p = 8; bus.prescale = 6'd8;
    line_q.push_back(1'b0); line_q.push_back(1'b0);
    repeat (20) tick();
    chk("glitch_cnt", gl_cnt, 32'd1);
    chk("glitch_bitcnt", max_bit, 32'd0);
    chk("glitch_dv", dv_cnt, 32'd0);
    chk("glitch_pdata", {24'd0, bus.p_data}, {24'd0, exp_pd});

    // Two frames with no idle gap, odd parity.
    clear_obs();
    push_frame(32, 6'd32, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1);
    push_frame(32, 6'd32, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1);
    drain(1'b0);
    exp_pd = 8'hFF;
    chk("b2b_dv", dv_cnt, 32'd2);
    chk("b2b_npd", pd_q.size(), 32'd2);
    chk("b2b_pd0", {24'd0, pd_q[0]}, 32'h00);
    chk("b2b_pd1", {24'd0, pd_q[1]}, 32'hFF);

    do_frame("presc_low", 8, 6'd2, 8'hC3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of data bit 5.
    clear_obs();
    push_frame(8, 6'd8, 8'h77, 1'b0, 1'b0, 1'b0, 1'b1);
    k = 0;
    while (bus.bit_cnt != 4'd5 && k < 400) begin tick(); k++; end
    chk("rst_reach_bit5", {31'd0, (k < 400)}, 32'd1);
    #1 rst = 1'b0;
    #1 chk("rst_mid_outs", all_outs(), 32'd0);
    line_q.delete();
    bus.rx_in = 1'b1; bus.sample_vld = 1'b0; bus.par_error = 1'b0;
    rec_stp = 1'b0; rec_pd = 1'b0;
    exp_pd = 8'h00;
    @(negedge clk);
    repeat (2) tick();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) tick();
    chk("rst_abort_dv", dv_cnt, 32'd0);
    do_frame("5a_after_rst", 8, 6'd8, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int n = 0; n < 12; n++) begin
      p  = 8 << $urandom_range(0, 2);
      pe = 1'($urandom_range(0, 1));
      pt = 1'($urandom_range(0, 1));
      bp = ($urandom_range(0, 4) == 0);
      bs = ($urandom_range(0, 5) == 0);
      do_frame("rand", p, 6'(p), 8'($urandom_range(0, 255)), pe, pt, bp, bs, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
